// File: rtl/intr_ctrl_nested.sv
// Prioritised, nesting interrupt controller: N_CH request lines funnelled onto one
// intr/inta handshake, with masking, pending/in-service tracking and non-specific EOI.
module intr_ctrl_nested #(
  parameter int                N_CH      = 8,
  parameter logic [N_CH-1:0]   EDGE_MASK = {N_CH{1'b1}},
  parameter int                VEC_W     = $clog2(N_CH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_CH-1:0]   irq,
  input  logic              mask_we,
  input  logic [N_CH-1:0]   mask_wdata,
  output logic              intr,
  input  logic              inta,
  output logic [VEC_W-1:0]  vector,
  output logic              vector_valid,
  input  logic              eoi,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   in_service
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t             state_reg, state_next;
  logic               intr_reg, intr_next;
  logic [VEC_W-1:0]   vector_reg, vector_next;
  logic [N_CH-1:0]    mask_reg;
  logic [N_CH-1:0]    irq_prev_reg;
  logic [N_CH-1:0]    pending_reg, pending_next;
  logic [N_CH-1:0]    in_service_reg, in_service_next;

  logic [N_CH-1:0]    req_vec;
  logic [N_CH-1:0]    rise;
  logic [N_CH-1:0]    ack_onehot;
  logic [VEC_W-1:0]   hi_req;
  logic [VEC_W-1:0]   hi_isr;
  logic               eligible;
  logic               ack_take;

  assign req_vec = pending_reg & ~mask_reg;

  // Lowest index wins; N_CH stands for "nothing set".
  always_comb begin
    hi_req = VEC_W'(N_CH);
    hi_isr = VEC_W'(N_CH);
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_vec[i])
        hi_req = VEC_W'(i);
      if (in_service_reg[i])
        hi_isr = VEC_W'(i);
    end
  end

  assign eligible = (|req_vec) && (hi_req < hi_isr);

  always_comb begin
    state_next  = state_reg;
    intr_next   = intr_reg;
    vector_next = vector_reg;
    ack_take    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (eligible) begin
          state_next = REQ;
          intr_next  = 1'b1;
        end
      end
      REQ: begin
        // Priority is re-resolved at the acknowledge; intr is never withdrawn early.
        if (inta) begin
          state_next = ACK;
          intr_next  = 1'b0;
          if (eligible) begin
            ack_take    = 1'b1;
            vector_next = hi_req;
          end else begin
            vector_next = VEC_W'(N_CH);
          end
        end
      end
      ACK: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign rise[gi]       = irq[gi] & ~irq_prev_reg[gi];
      assign ack_onehot[gi] = ack_take && (hi_req == VEC_W'(gi));
      // Edge channels keep a coincident new edge even when acknowledged this cycle.
      if (EDGE_MASK[gi]) begin : g_edge
        assign pending_next[gi] = (pending_reg[gi] & ~ack_onehot[gi]) | rise[gi];
      end else begin : g_level
        assign pending_next[gi] = irq[gi];
      end
    end
  endgenerate

  // EOI retires the highest-priority in-service bit before a new one is added.
  assign in_service_next = (eoi ? (in_service_reg & (in_service_reg - N_CH'(1)))
                                : in_service_reg) | ack_onehot;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      intr_reg       <= 1'b0;
      vector_reg     <= '0;
      mask_reg       <= '1;
      irq_prev_reg   <= '0;
      pending_reg    <= '0;
      in_service_reg <= '0;
    end else begin
      state_reg      <= state_next;
      intr_reg       <= intr_next;
      vector_reg     <= vector_next;
      irq_prev_reg   <= irq;
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      if (mask_we)
        mask_reg <= mask_wdata;
    end
  end

  assign intr         = intr_reg;
  assign vector       = vector_reg;
  assign vector_valid = (state_reg == ACK);
  assign pending      = pending_reg;
  assign in_service   = in_service_reg;

endmodule

// File: tb/tb_intr_ctrl_nested.sv
// Bench for intr_ctrl_nested: stack-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_intr_ctrl_nested;
  localparam int N = 8;
  localparam logic [N-1:0] EDGES = 8'hFE;  // ch0 level, the rest edge

  logic         Clk = 1'b0;
  logic         Reset;
  logic [N-1:0] irq;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         intr;
  logic         inta;
  logic [3:0]   vector;
  logic         vector_valid;
  logic         eoi;
  logic [N-1:0] pending;
  logic [N-1:0] in_service;

  intr_ctrl_nested #(.N_CH(N), .EDGE_MASK(EDGES), .VEC_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .intr(intr), .inta(inta), .vector(vector), .vector_valid(vector_valid),
    .eoi(eoi), .pending(pending), .in_service(in_service)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-service channels kept as a nesting stack (top = innermost),
  // handshake as a phase number (0 idle, 1 intr raised, 2 vector strobe).
  int           stack[$];
  bit [N-1:0]   m_mask = '1;
  bit [N-1:0]   m_pend = '0;
  bit [N-1:0]   m_prev = '0;
  int           phase  = 0;
  int           m_vec  = 0;

  function automatic logic [N-1:0] isr_bits();
    logic [N-1:0] b = '0;
    foreach (stack[k]) b[stack[k]] = 1'b1;
    return b;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    int lo, top;
    bit elig, acc;
    if (Reset) begin
      stack.delete();
      m_mask = '1; m_pend = '0; m_prev = '0; phase = 0; m_vec = 0;
    end else begin
      lo = N;
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i] && !m_mask[i]) lo = i;
      top  = (stack.size() == 0) ? N : stack[stack.size() - 1];
      elig = (lo < N) && (lo < top);
      acc  = (phase == 1) && inta && elig;
      if (phase == 1 && inta) m_vec = acc ? lo : N;
      if (eoi && stack.size() > 0) void'(stack.pop_back());
      if (acc) stack.push_back(lo);
      for (int i = 0; i < N; i++) begin
        if (EDGES[i]) m_pend[i] = (m_pend[i] && !(acc && lo == i)) || (irq[i] && !m_prev[i]);
        else          m_pend[i] = irq[i];
      end
      m_prev = irq;
      if (mask_we) m_mask = mask_wdata;
      case (phase)
        0: if (elig) phase = 1;
        1: if (inta) phase = 2;
        default: phase = 0;
      endcase
    end
  end

  always @(negedge Clk) begin
    chk("m_intr",   32'(intr),         32'(phase == 1));
    chk("m_valid",  32'(vector_valid), 32'(phase == 2));
    chk("m_vector", 32'(vector),       32'(m_vec));
    chk("m_pend",   32'(pending),      32'(m_pend));
    chk("m_isr",    32'(in_service),   32'(isr_bits()));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic pulse_irq(input int ch);
    irq[ch] = 1'b1;
    tick();
    irq[ch] = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic do_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; inta = 1'b0; eoi = 1'b0;
    tick(2);
    chk("rst_intr", 32'(intr), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_isr",  32'(in_service), 0);
    Reset = 1'b0;
    tick();
    write_mask(8'h00);

    // Basic: edge on ch3
    pulse_irq(3);
    chk("basic_pend", 32'(pending), 32'h08);
    chk("basic_intr_early", 32'(intr), 0);
    tick();
    chk("basic_intr", 32'(intr), 1);
    do_inta();
    chk("basic_valid", 32'(vector_valid), 1);
    chk("basic_vec", 32'(vector), 3);
    chk("basic_isr", 32'(in_service), 32'h08);
    chk("basic_pend0", 32'(pending), 0);
    tick();
    chk("basic_valid_off", 32'(vector_valid), 0);
    do_eoi();
    tick();

    // Priority: ch5 raises intr, ch1 arrives in REQ and wins at inta
    pulse_irq(5);
    tick();
    pulse_irq(1);
    do_inta();
    chk("prio_vec", 32'(vector), 1);
    chk("prio_pend", 32'(pending), 32'h20);
    chk("prio_isr", 32'(in_service), 32'h02);
    tick(3);
    chk("prio_wait", 32'(intr), 0);
    do_eoi();
    chk("prio_eoi_intr", 32'(intr), 0);
    tick();
    chk("prio_reraise", 32'(intr), 1);
    do_inta();
    chk("prio_vec5", 32'(vector), 5);
    tick();
    do_eoi();
    tick();

    // Nesting: ch4 in service, ch2 preempts, ch6 waits
    pulse_irq(4);
    tick();
    do_inta();
    chk("nest_vec4", 32'(vector), 4);
    tick();
    pulse_irq(2);
    tick();
    chk("nest_intr2", 32'(intr), 1);
    do_inta();
    chk("nest_vec2", 32'(vector), 2);
    chk("nest_isr", 32'(in_service), 32'h14);
    tick();
    pulse_irq(6);
    tick(3);
    chk("nest_no_intr6", 32'(intr), 0);
    chk("nest_pend6", 32'(pending), 32'h40);
    do_eoi();
    chk("nest_isr_a", 32'(in_service), 32'h10);
    tick();
    chk("nest_still_blocked", 32'(intr), 0);
    do_eoi();
    chk("nest_isr_b", 32'(in_service), 32'h00);
    tick();
    chk("nest_intr6", 32'(intr), 1);
    do_inta();
    chk("nest_vec6", 32'(vector), 6);
    chk("nest_isr6", 32'(in_service), 32'h40);
    tick();
    do_eoi();
    tick();

    // Masking: masked edge on ch1 latches, fires after unmask
    write_mask(8'h02);
    pulse_irq(1);
    tick(2);
    chk("mask_pend", 32'(pending), 32'h02);
    chk("mask_blocked", 32'(intr), 0);
    write_mask(8'h00);
    chk("mask_next", 32'(intr), 0);
    tick();
    chk("mask_fire", 32'(intr), 1);
    do_inta();
    chk("mask_vec", 32'(vector), 1);
    tick();
    do_eoi();
    tick();

    // Level ch0 drops before inta -> spurious vector
    irq[0] = 1'b1;
    tick(2);
    chk("lvl_intr", 32'(intr), 1);
    irq[0] = 1'b0;
    tick();
    chk("lvl_hold_intr", 32'(intr), 1);
    do_inta();
    chk("lvl_spur_vec", 32'(vector), 8);
    chk("lvl_spur_valid", 32'(vector_valid), 1);
    chk("lvl_isr", 32'(in_service), 0);
    tick();

    // eoi and inta in the same cycle
    pulse_irq(4);
    tick();
    do_inta();
    tick();
    chk("ei_isr10", 32'(in_service), 32'h10);
    pulse_irq(2);
    tick();
    eoi = 1'b1; inta = 1'b1;
    tick();
    eoi = 1'b0; inta = 1'b0;
    chk("ei_vec", 32'(vector), 2);
    chk("ei_isr", 32'(in_service), 32'h04);
    tick();
    do_eoi();
    tick();

    // Asynchronous reset in the middle of REQ
    pulse_irq(3);
    tick();
    chk("ar_intr_pre", 32'(intr), 1);
    #1 Reset = 1'b1;
    #1;
    chk("ar_intr", 32'(intr), 0);
    chk("ar_pend", 32'(pending), 0);
    tick(2);
    Reset = 1'b0;
    do_inta();
    chk("ar_no_valid", 32'(vector_valid), 0);
    chk("ar_no_intr", 32'(intr), 0);
    pulse_irq(3);
    tick(3);
    chk("ar_mask_ff", 32'(intr), 0);
    chk("ar_pend3", 32'(pending), 32'h08);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
